// File: rtl/core3_debug_pkg.sv
// core3_debug_pkg: shared state encoding, jdo field positions and defaults for the debug memory port
package core3_debug_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_e;
  localparam int READ_REQ_BIT = 34;
  localparam int DATA_MSB = 31;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/core3_cpu_2_debug_timeout.sv
// core3_cpu_2_debug_timeout: 8-bit saturating stall counter; expired once LIMIT-1 stalls have already been seen
module core3_cpu_2_debug_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [7:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
  end
  assign expired_o = cnt_q >= 8'(LIMIT - 1);
endmodule

// File: rtl/core3_cpu_2_debug_mem_access.sv
// core3_cpu_2_debug_mem_access: JTAG-driven Avalon-MM master for debug monitor memory reads/writes
module core3_cpu_2_debug_mem_access
  import core3_debug_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  state_e            state_q;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [31:0]       mon_q;
  logic              ready_q, error_q, drop_q;
  logic              busy, any_strobe, expired, done, abort;
  logic              unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[33:32]};
  assign busy       = state_q != ST_IDLE;
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign done       = busy && !avm_waitrequest;
  assign abort      = busy && avm_waitrequest && expired;
  assign addr_d     = addr_q + (ADDR_W-2)'(1);
  core3_cpu_2_debug_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst_n    (reset_n),
    .clr_i    (!busy),
    .en_i     (busy && avm_waitrequest),
    .expired_o(expired)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      mon_q   <= '0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
      drop_q  <= 1'b0;
    end else if (!busy) begin
      if (take_action_ocimem_a) begin
        addr_q <= jdo[ADDR_W-1:2];
        if (jdo[READ_REQ_BIT]) begin
          state_q <= ST_READ;
          ready_q <= 1'b0;
          error_q <= 1'b0;
          drop_q  <= 1'b0;
        end
      end else if (take_action_ocimem_b) begin
        mon_q   <= jdo[DATA_MSB:0];
        state_q <= ST_WRITE;
        ready_q <= 1'b0;
        error_q <= 1'b0;
        drop_q  <= 1'b0;
      end else if (take_no_action_ocimem_a) begin
        state_q <= ST_READ;
        ready_q <= 1'b0;
        error_q <= 1'b0;
        drop_q  <= 1'b0;
      end
    end else if (done || abort) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      error_q <= abort | drop_q | any_strobe;
      if (done) addr_q <= addr_d;
      if (done && state_q == ST_READ) mon_q <= avm_readdata;
    end else if (any_strobe) begin
      drop_q <= 1'b1;
    end
  end
  assign avm_address    = {addr_q, 2'b00};
  assign avm_read       = state_q == ST_READ;
  assign avm_write      = state_q == ST_WRITE;
  assign avm_writedata  = mon_q;
  assign avm_byteenable = 4'hF;
  assign MonDReg        = mon_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = error_q;
endmodule

// File: tb/tb_core3_cpu_2_debug_mem_access.sv
// tb_core3_cpu_2_debug_mem_access: table-driven directed checks plus reset-during-stall sequence
module tb_core3_cpu_2_debug_mem_access;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        sa = 1'b0, sb = 1'b0, sn = 1'b0;
  logic [31:0] avm_address, avm_writedata, avm_readdata = '0, MonDReg;
  logic        avm_read, avm_write, avm_waitrequest = 1'b0;
  logic [3:0]  avm_byteenable;
  logic        monitor_ready, monitor_error;
  int          n_chk = 0, n_fail = 0;

  typedef struct {
    int          kind;
    logic [37:0] j;
    int          ws;
    logic [31:0] rd;
    int          inj_at;
    int          cyc;
    logic [31:0] areq;
    logic [31:0] aft;
    logic [31:0] mon;
    logic        err;
    logic        wr;
  } vec_t;
  vec_t vecs[12];

  core3_cpu_2_debug_mem_access dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(sa), .take_action_ocimem_b(sb), .take_no_action_ocimem_a(sn),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] mk(input logic rd, input logic [31:0] v);
    return {3'b000, rd, 2'b00, v};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    logic [31:0] a0, d0;
    logic stable, saw_w, both, rdy_low;
    avm_readdata = v.rd;
    @(negedge clk);
    jdo = v.j;
    sa = v.kind == 0 || v.kind == 3;
    sb = v.kind == 1 || v.kind == 3 || v.kind == 4;
    sn = v.kind == 2 || v.kind == 4;
    @(negedge clk);
    sa = 0; sb = 0; sn = 0;
    n = 0; a0 = avm_address; d0 = avm_writedata;
    stable = 1; saw_w = 0; both = 0; rdy_low = 1;
    while ((avm_read || avm_write) && n < 400) begin
      stable  &= (avm_address == a0) && (avm_writedata == d0);
      saw_w   |= avm_write;
      both    |= avm_read && avm_write;
      rdy_low &= !monitor_ready;
      avm_waitrequest = n < v.ws;
      sb = n == v.inj_at;
      if (n == v.inj_at) jdo = mk(1'b0, 32'hAAAA5555);
      n++;
      @(negedge clk);
    end
    sb = 0;
    avm_waitrequest = 0;
    chk({tag, ".cycles"}, 32'(n), 32'(v.cyc));
    if (v.cyc > 0) chk({tag, ".req_addr"}, a0, v.areq);
    chk({tag, ".stable"}, 32'(stable), 32'd1);
    chk({tag, ".busy_not_ready"}, 32'(rdy_low), 32'd1);
    chk({tag, ".rd_wr_both"}, 32'(both), 32'd0);
    chk({tag, ".write_seen"}, 32'(saw_w), 32'(v.wr));
    chk({tag, ".addr_after"}, avm_address, v.aft);
    chk({tag, ".mondreg"}, MonDReg, v.mon);
    chk({tag, ".ready"}, 32'(monitor_ready), 32'd1);
    chk({tag, ".error"}, 32'(monitor_error), 32'(v.err));
  endtask

  initial begin
    vec_t pr;
    vecs[0]  = '{0, mk(1, 32'h100),      0,    32'hDEADBEEF, -1, 1,   32'h100,      32'h104,      32'hDEADBEEF, 0, 0};
    vecs[1]  = '{1, mk(0, 32'h12345678), 3,    32'h0,        -1, 4,   32'h104,      32'h108,      32'h12345678, 0, 1};
    vecs[2]  = '{0, mk(0, 32'hFFFFFFF8), 0,    32'h0,        -1, 0,   32'h0,        32'hFFFFFFF8, 32'h12345678, 0, 0};
    vecs[3]  = '{2, mk(0, 32'h0),        0,    32'h11111111, -1, 1,   32'hFFFFFFF8, 32'hFFFFFFFC, 32'h11111111, 0, 0};
    vecs[4]  = '{2, mk(0, 32'h0),        0,    32'h22222222, -1, 1,   32'hFFFFFFFC, 32'h0,        32'h22222222, 0, 0};
    vecs[5]  = '{2, mk(0, 32'h0),        0,    32'h33333333, -1, 1,   32'h0,        32'h4,        32'h33333333, 0, 0};
    vecs[6]  = '{3, mk(0, 32'h300),      0,    32'h0,        -1, 0,   32'h0,        32'h300,      32'h33333333, 0, 0};
    vecs[7]  = '{2, mk(0, 32'h0),        2,    32'h44444444,  1, 3,   32'h300,      32'h304,      32'h44444444, 1, 0};
    vecs[8]  = '{0, mk(1, 32'h40),       0,    32'h55555555, -1, 1,   32'h40,       32'h44,       32'h55555555, 0, 0};
    vecs[9]  = '{2, mk(0, 32'h0),        1000, 32'h66666666, -1, 255, 32'h44,       32'h44,       32'h55555555, 1, 0};
    vecs[10] = '{1, mk(0, 32'hCAFEF00D), 0,    32'h0,        -1, 1,   32'h44,       32'h48,       32'hCAFEF00D, 0, 1};
    vecs[11] = '{4, mk(0, 32'h0BADF00D), 0,    32'h0,        -1, 1,   32'h48,       32'h4C,       32'h0BADF00D, 0, 1};
    repeat (2) @(negedge clk);
    chk("rst.addr", avm_address, 32'h0);
    chk("rst.mondreg", MonDReg, 32'h0);
    chk("rst.read", 32'(avm_read), 32'd0);
    chk("rst.write", 32'(avm_write), 32'd0);
    chk("rst.ready", 32'(monitor_ready), 32'd1);
    chk("rst.error", 32'(monitor_error), 32'd0);
    chk("rst.byteenable", 32'(avm_byteenable), 32'hF);
    reset_n = 1;
    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));
    // reset asserted while a write is stalled must drop the request immediately
    @(negedge clk);
    jdo = mk(1'b0, 32'h77777777);
    sb = 1;
    @(negedge clk);
    sb = 0;
    avm_waitrequest = 1;
    chk("rstw.write_started", 32'(avm_write), 32'd1);
    repeat (2) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("rstw.write", 32'(avm_write), 32'd0);
    chk("rstw.read", 32'(avm_read), 32'd0);
    chk("rstw.addr", avm_address, 32'h0);
    chk("rstw.mondreg", MonDReg, 32'h0);
    chk("rstw.ready", 32'(monitor_ready), 32'd1);
    chk("rstw.error", 32'(monitor_error), 32'd0);
    @(negedge clk);
    avm_waitrequest = 0;
    reset_n = 1;
    pr = '{0, mk(1, 32'h10), 0, 32'h88888888, -1, 1, 32'h10, 32'h14, 32'h88888888, 0, 0};
    run_vec(pr, "post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/core3_cpu_2_debug_mem_access.md
CORE3_CPU_2_DEBUG_MEM_ACCESS -- requirements
Module: core3_cpu_2_debug_mem_access

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max consecutive avm_waitrequest cycles before abort (1..255).
REQ-002 Parameter: ADDR_W, 32, byte-address width of avm_address.
REQ-003 Port: clk  in  1  single clock for all logic; one clock, no other clock domains.
REQ-004 Port: reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Port: jdo  in  38  JTAG data word from the debug sysclk stage, valid while a take_* strobe is high.
REQ-006 Port: take_action_ocimem_a  in  1  one-cycle strobe: load address; optionally start a read.
REQ-007 Port: take_action_ocimem_b  in  1  one-cycle strobe: write jdo[31:0] at current address.
REQ-008 Port: take_no_action_ocimem_a  in  1  one-cycle strobe: read at current address (auto-increment read).
REQ-009 Port: avm_address  out  ADDR_W  word-aligned byte address; bits [1:0] always 0.
REQ-010 Port: avm_read / avm_write  out  1 each  Avalon-MM master request strobes, never both high.
REQ-011 Port: avm_writedata  out  32  write data; avm_byteenable out 4, constant 4'hF.
REQ-012 Port: avm_readdata  in  32; avm_waitrequest  in  1  slave stall.
REQ-013 Port: MonDReg  out  32  monitor data register, returned to the JTAG tck stage.
REQ-014 Port: monitor_ready  out  1  high when idle and last command complete.
REQ-015 Port: monitor_error  out  1  high when last command aborted or was dropped.

Function
REQ-016 FSM states IDLE, READ, WRITE; commands accepted only in IDLE.
REQ-017 Strobe priority in same cycle: ocimem_a > ocimem_b > no_action_ocimem_a; lower-priority strobes that cycle are discarded without error.
REQ-018 ocimem_a in IDLE: addr[ADDR_W-1:2] <= jdo[ADDR_W-1:2]; if jdo[34]=1 go READ at the new address next cycle, else stay IDLE with monitor_ready=1 unchanged.
REQ-019 ocimem_b in IDLE: MonDReg <= jdo[31:0], go WRITE; avm_write asserted from the next cycle.
REQ-020 no_action_ocimem_a in IDLE: go READ at current addr.
REQ-021 On entering READ/WRITE: monitor_ready <= 0, monitor_error <= 0, timeout counter cleared.
REQ-022 In READ/WRITE the request is held with stable address/data until a cycle with avm_waitrequest=0; that cycle completes the transfer.
REQ-023 Read completion: MonDReg <= avm_readdata, addr <= addr+4; write completion: addr <= addr+4; both return to IDLE with monitor_ready=1 the following cycle.
REQ-024 Address increment wraps modulo 2^ADDR_W (0xFFFFFFFC -> 0x00000000).
REQ-025 Timeout: TIMEOUT_CYCLES consecutive waitrequest=1 cycles -> drop request, return IDLE, monitor_ready=1, monitor_error=1, MonDReg and addr unchanged.
REQ-026 Any strobe arriving in READ/WRITE is dropped and sets monitor_error=1 at completion; transfer in progress unaffected.
REQ-027 Latency with zero wait states: strobe cycle N, request cycle N+1, monitor_ready=1 at N+2.

Reset
REQ-028 While reset_n=0: state IDLE, addr 0, MonDReg 0, avm_read 0, avm_write 0, monitor_ready 1, monitor_error 0, timeout counter 0.
REQ-029 Reset mid-transfer deasserts avm_read/avm_write asynchronously; no completion or address increment is recorded.

Structure
REQ-030 Shared package core3_debug_pkg holds the state enum, jdo bit positions (READ_REQ_BIT=34, DATA_MSB=31) and default TIMEOUT_CYCLES.
REQ-031 One sub-module: core3_cpu_2_debug_timeout, 8-bit saturating stall counter with clear/enable and expired output.

Verification
REQ-032 ocimem_a jdo addr 0x100, jdo[34]=1, 0 wait states -> avm_read one cycle at 0x100, MonDReg=readdata 0xDEADBEEF, ready high at N+2, addr=0x104.
REQ-033 ocimem_b jdo[31:0]=0x12345678 with 3 wait states -> avm_write held 4 cycles at constant address/data, ready after, addr +4.
REQ-034 Three back-to-back no_action reads from 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-035 waitrequest stuck high -> abort after exactly 255 stall cycles, monitor_error=1, ready=1, MonDReg unchanged.
REQ-036 ocimem_b during an active read -> read completes normally, write not issued, monitor_error=1; ocimem_a and ocimem_b in the same cycle -> only the address load happens.
REQ-037 reset_n low during WRITE stall -> avm_write low immediately, all REQ-028 values, next command executes normally.
